// File: rtl/serial_parity_checker.sv
// Framed serial receiver: deserialises DATA_W bits LSB-first, folds them into a running
// XOR parity accumulator and checks the trailing parity bit against it.
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shreg;
    logic               acc;
    logic               accept;
    logic               last_data_bit;

    // START always wins, so a bit is only consumed on edges without it.
    assign accept        = bit_valid & ~start;
    assign last_data_bit = (cnt == CNT_W'(DATA_W - 1));
    assign busy          = (state != IDLE);

    // NOTE: every register below uses non-blocking (<=) so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before any branch, otherwise a missed case infers a latch.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = DATA;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                DATA:    if (accept && last_data_bit) state_nxt = PARITY;
                PARITY:  if (accept) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            shreg      <= '0;
            acc        <= ODD;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (start) begin
                cnt   <= '0;
                shreg <= '0;
                acc   <= ODD;
            end else if (accept) begin
                case (state)
                    DATA: begin
                        // Shift right so the first bit received ends up in bit 0.
                        shreg <= {bit_in, shreg[DATA_W-1:1]};
                        acc   <= acc ^ bit_in;
                        cnt   <= cnt + CNT_W'(1);
                    end
                    PARITY: begin
                        data_out   <= shreg;
                        parity_err <= acc ^ bit_in;
                        data_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
